// File: rtl/arbitro_pkg.sv
// Shared constants for the round-robin FIFO scheduler: fan-in/out count, destination field, FSM encodings.
package arbitro_pkg;
    localparam int N_FIFOS = 4;
    localparam int DEST_HI = 5;
    localparam int DEST_LO = 4;
    localparam int DEST_W  = DEST_HI - DEST_LO + 1;

    localparam logic ESPERA  = 1'b0;
    localparam logic ARBITRA = 1'b1;
endpackage

// File: rtl/rr_selector.sv
// Combinational round-robin pick: first eligible input starting at ptr, wrapping mod N_FIFOS.
// Zero latency; no state.
module rr_selector
    import arbitro_pkg::*;
(
    input  logic [N_FIFOS-1:0] eligible,
    input  logic [1:0]         ptr,
    output logic               grant_valid,
    output logic [1:0]         grant_idx
);

    // Walk offsets from farthest to nearest so the nearest eligible overwrites.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = ptr;
        for (int k = N_FIFOS - 1; k >= 0; k--) begin
            if (eligible[ptr + 2'(k)]) begin
                grant_valid = 1'b1;
                grant_idx   = ptr + 2'(k);
            end
        end
    end

endmodule

// File: rtl/arbitro_rr_fifos.sv
// Round-robin drain of four FWFT input FIFOs into four output FIFOs chosen by the word's top bits.
// Pop is combinational; push/data_out follow one cycle later. An input whose destination is almost full is skipped.
module arbitro_rr_fifos
    import arbitro_pkg::*;
#(
    parameter int DATA_W = DEST_HI + 1,
    parameter int CNT_W  = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        active_in,
    input  logic [N_FIFOS-1:0]          empty_in,
    input  logic [N_FIFOS*DATA_W-1:0]   data_in,
    input  logic [N_FIFOS-1:0]          almost_full_in,
    output logic [N_FIFOS-1:0]          pop,
    output logic [N_FIFOS-1:0]          push,
    output logic [DATA_W-1:0]           data_out,
    output logic                        pausa,
    input  logic [1:0]                  cnt_sel,
    output logic [CNT_W-1:0]            cnt_out
);

    logic                 state;
    logic [1:0]           ptr;
    logic [N_FIFOS-1:0]   eligible;
    logic                 grant_valid;
    logic [1:0]           grant_idx;
    logic                 take;
    logic [DATA_W-1:0]    head [N_FIFOS];
    logic [CNT_W-1:0]     cnt  [N_FIFOS];

    always_comb begin
        for (int i = 0; i < N_FIFOS; i++) begin
            head[i]     = data_in[i*DATA_W +: DATA_W];
            eligible[i] = !empty_in[i] && !almost_full_in[head[i][DATA_W-1 -: DEST_W]];
        end
    end

    rr_selector u_sel (
        .eligible    (eligible),
        .ptr         (ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // A falling active_in stops new pops immediately; the registered word still drains.
    assign take    = (state == ARBITRA) && active_in && grant_valid;
    assign pop     = take ? (N_FIFOS'(1) << grant_idx) : '0;
    assign pausa   = (state == ARBITRA) && !(&empty_in) && !grant_valid;
    assign cnt_out = cnt[cnt_sel];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ESPERA;
            ptr      <= '0;
            push     <= '0;
            data_out <= '0;
            for (int j = 0; j < N_FIFOS; j++) begin
                cnt[j] <= '0;
            end
        end else begin
            state <= active_in ? ARBITRA : ESPERA;
            if (take) begin
                ptr      <= grant_idx + 2'd1;
                data_out <= head[grant_idx];
                push     <= N_FIFOS'(1) << head[grant_idx][DATA_W-1 -: DEST_W];
            end else begin
                push <= '0;
            end
            for (int j = 0; j < N_FIFOS; j++) begin
                if (push[j]) begin
                    cnt[j] <= cnt[j] + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_arbitro_rr_fifos.sv
// Scoreboard bench: queue-based FIFO/arbiter model predicts pops; a negedge monitor checks pushes and counters.
module tb_arbitro_rr_fifos;

    typedef struct {
        logic [5:0] w;
        int         due;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        active_in;
    logic [3:0]  empty_in;
    logic [23:0] data_in;
    logic [3:0]  almost_full_in;
    logic [3:0]  pop;
    logic [3:0]  push;
    logic [5:0]  data_out;
    logic        pausa;
    logic [1:0]  cnt_sel;
    logic [7:0]  cnt_out;

    arbitro_rr_fifos #(.DATA_W(6), .CNT_W(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .active_in      (active_in),
        .empty_in       (empty_in),
        .data_in        (data_in),
        .almost_full_in (almost_full_in),
        .pop            (pop),
        .push           (push),
        .data_out       (data_out),
        .pausa          (pausa),
        .cnt_sel        (cnt_sel),
        .cnt_out        (cnt_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    logic       chk_en  = 1'b0;

    // Reference model state
    logic [5:0] fq [4][$];
    exp_t       eq [$];
    logic       mrun = 1'b0;
    int         mptr = 0;
    logic [7:0] cnt_m [4];
    logic [5:0] m_last = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic put(input int f, input logic [1:0] d);
        logic [3:0] lo;
        lo = 4'($urandom);
        fq[f].push_back({d, lo});
    endtask

    task automatic step(input logic rst_n, input logic act, input logic [3:0] af, input logic [1:0] sel);
        logic [3:0] elig;
        logic [3:0] exp_pop;
        logic       exp_pausa;
        logic       nonempty;
        logic [5:0] h;
        logic [5:0] w;
        int         g;
        @(posedge clk);
        cyc++;
        #1;
        reset          = rst_n;
        active_in      = act;
        almost_full_in = af;
        cnt_sel        = sel;
        for (int i = 0; i < 4; i++) begin
            if (fq[i].size() == 0) begin
                empty_in[i]        = 1'b1;
                data_in[i*6 +: 6]  = 6'($urandom);
            end else begin
                empty_in[i]        = 1'b0;
                data_in[i*6 +: 6]  = fq[i][0];
            end
        end
        #2;
        nonempty = 1'b0;
        for (int i = 0; i < 4; i++) begin
            elig[i] = 1'b0;
            if (fq[i].size() != 0) begin
                h        = fq[i][0];
                nonempty = 1'b1;
                elig[i]  = !af[h[5:4]];
            end
        end
        g = -1;
        if (mrun && act) begin
            for (int k = 0; k < 4; k++) begin
                if (g < 0 && elig[(mptr + k) % 4]) g = (mptr + k) % 4;
            end
        end
        exp_pop   = (g >= 0) ? 4'(1 << g) : 4'd0;
        exp_pausa = mrun && nonempty && (elig == 4'd0);
        if (chk_en) begin
            chk("pop", 32'(pop), 32'(exp_pop));
            chk("pausa", 32'(pausa), 32'(exp_pausa));
        end
        if (g >= 0) begin
            w = fq[g].pop_front();
            if (rst_n) eq.push_back('{w, cyc + 1});
            mptr = (g + 1) % 4;
        end
        mrun = rst_n && act;
        if (!rst_n) mptr = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((fq[0].size() + fq[1].size() + fq[2].size() + fq[3].size()) != 0 && n < 200) begin
            step(1'b1, 1'b1, 4'd0, 2'(n));
            n++;
        end
        chk("drain_bound", 32'(n < 200), 32'd1);
    endtask

    // Monitor: push/data_out/counters against the queued expectations
    logic [3:0] mon_push;
    logic [5:0] mon_w;
    always @(negedge clk) begin
        if (chk_en) begin
            mon_push = 4'd0;
            if (eq.size() != 0 && eq[0].due == cyc) begin
                mon_w    = eq[0].w;
                void'(eq.pop_front());
                mon_push = 4'(1 << mon_w[5:4]);
                m_last   = mon_w;
            end
            chk("push", 32'(push), 32'(mon_push));
            chk("data_out", 32'(data_out), 32'(m_last));
            chk("cnt_out", 32'(cnt_out), 32'(cnt_m[cnt_sel]));
            if (mon_push != 4'd0) cnt_m[mon_w[5:4]] = cnt_m[mon_w[5:4]] + 8'd1;
            if (!reset) begin
                m_last = '0;
                for (int j = 0; j < 4; j++) cnt_m[j] = '0;
            end
        end
    end

    initial begin
        for (int j = 0; j < 4; j++) cnt_m[j] = '0;
        reset = 1'b0; active_in = 1'b0; empty_in = 4'hF; data_in = '0;
        almost_full_in = 4'd0; cnt_sel = 2'd0;

        // Reset, then idle with full FIFOs and active low
        step(1'b0, 1'b0, 4'd0, 2'd0);
        chk_en = 1'b1;
        step(1'b0, 1'b0, 4'd0, 2'd0);
        for (int i = 0; i < 4; i++) put(i, 2'(i));
        for (int s = 0; s < 4; s++) step(1'b1, 1'b0, 4'd0, 2'(s));

        // Plain rotation 0,1,2,3 with dest = source
        for (int s = 0; s < 8; s++) step(1'b1, 1'b1, 4'd0, 2'(s));

        // Head-of-line block on FIFO1 (dest 2 almost full)
        put(1, 2'd2);
        for (int k = 0; k < 3; k++) begin put(0, 2'(k % 2)); put(3, 2'd3); end
        for (int s = 0; s < 6; s++) step(1'b1, 1'b1, 4'b0100, 2'(s));
        for (int s = 0; s < 4; s++) step(1'b1, 1'b1, 4'b0000, 2'(s));
        drain();

        // Only FIFO2 present, destination blocked -> pausa, then release
        put(2, 2'd1);
        for (int s = 0; s < 3; s++) step(1'b1, 1'b1, 4'b0010, 2'd1);
        for (int s = 0; s < 3; s++) step(1'b1, 1'b1, 4'b0000, 2'd1);

        // Counter wrap on dest 0
        for (int k = 0; k < 260; k++) put(0, 2'd0);
        for (int s = 0; s < 265; s++) step(1'b1, 1'b1, 4'd0, 2'd0);

        // Reset right on a popping cycle, then lowest-index restart
        put(1, 2'd3); put(1, 2'd2); put(2, 2'd1); put(2, 2'd0); put(3, 2'd2);
        step(1'b1, 1'b1, 4'd0, 2'd3);
        step(1'b0, 1'b1, 4'd0, 2'd3);
        for (int s = 0; s < 6; s++) step(1'b1, 1'b1, 4'd0, 2'(s));
        drain();

        // Randomized traffic, flags, enable and occasional reset
        for (int s = 0; s < 500; s++) begin
            if ($urandom_range(0, 2) != 0) put($urandom_range(0, 3), 2'($urandom));
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 9) != 0),
                 4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                 2'($urandom));
        end
        drain();
        step(1'b1, 1'b0, 4'd0, 2'd0);
        step(1'b1, 1'b0, 4'd0, 2'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
